cve2_lsu_split: RTL and testbench

Load/store unit that sits directly upstream of the writeback stage. It takes one memory request at a time from ID/EX and drives the word-aligned data bus. A misaligned access is split into two bus transactions. The unit returns load data (aligned and sign- or zero-extended), the register-file write enable, and the response valid/error flags that writeback consumes to retire loads and stores.

---
 rtl/cve2_lsu_split.sv | 250 +++++++++++++++++++++++++
 tb/tb_cve2_lsu_split.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_lsu_split.sv
// ---------------------------------------------------------------------------
// cve2_lsu_split
// Load/store unit placed just upstream of writeback. Takes one request at a
// time, drives a word-aligned data bus, and splits misaligned accesses into
// two bus transactions (or rejects them when MisalignedSplit = 0).
//
// Ports
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   lsu_req_i .. lsu_wdata_i: request from ID/EX (sampled only when idle)
//   lsu_busy_o              : unit is not idle
//   data_*                  : word-aligned memory bus (req/gnt, rvalid/err)
//   rf_wdata_lsu_o          : aligned, extended load result
//   rf_we_lsu_o             : register-file write for load data
//   lsu_resp_valid_o/err_o  : one-cycle completion pulse and its error flag
// ---------------------------------------------------------------------------
module cve2_lsu_split #(
    parameter bit MisalignedSplit = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] adder_result_ex_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID,
        ERR_RESP
    } state_e;

    state_e      r_state;
    state_e      w_stateNext;

    logic [31:0] r_addr;
    logic [1:0]  r_type;
    logic        r_we;
    logic        r_signExt;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata1;
    logic        r_err1;

    logic        w_inIdle;
    logic [31:0] w_curAddr;
    logic [1:0]  w_curType;
    logic        w_curWe;
    logic [31:0] w_curWdata;
    logic [1:0]  w_off;
    logic        w_isHalf;
    logic        w_isByte;
    logic        w_misaligned;
    logic        w_splitAccess;
    logic        w_secondPart;
    logic [3:0]  w_beBase;
    logic [7:0]  w_beWide;
    logic        w_busReq;
    logic        w_respValid;
    logic        w_respErr;
    logic [31:0] w_part1;
    logic [31:0] w_raw;
    logic [31:0] w_loadExt;

    // Request fields come straight from the inputs while idle (so the first
    // bus request can go out in the acceptance cycle) and from the capture
    // registers once the access is in flight.
    assign w_inIdle   = (r_state == IDLE);
    assign w_curAddr  = w_inIdle ? adder_result_ex_i : r_addr;
    assign w_curType  = w_inIdle ? lsu_type_i        : r_type;
    assign w_curWe    = w_inIdle ? lsu_we_i          : r_we;
    assign w_curWdata = w_inIdle ? lsu_wdata_i       : r_wdata;

    assign w_off    = w_curAddr[1:0];
    assign w_isHalf = (w_curType == 2'b01);
    assign w_isByte = (w_curType == 2'b10);

    // Type 11 falls through to word handling.
    assign w_misaligned  = (!w_isHalf && !w_isByte && (w_off != 2'd0)) ||
                           (w_isHalf && (w_off == 2'd3));
    assign w_splitAccess = MisalignedSplit && w_misaligned;
    assign w_secondPart  = w_splitAccess &&
                           ((r_state == WAIT_GNT) || (r_state == WAIT_RVALID));

    // Shifting the size mask across an 8-lane window gives the first-part
    // enables in the low nibble and the spill-over second-part enables in
    // the high nibble.
    always_comb begin
        if (w_isByte) begin
            w_beBase = 4'b0001;
        end else if (w_isHalf) begin
            w_beBase = 4'b0011;
        end else begin
            w_beBase = 4'b1111;
        end
    end

    assign w_beWide    = {4'b0000, w_beBase} << w_off;
    assign data_be_o   = w_secondPart ? w_beWide[7:4] : w_beWide[3:0];
    assign data_addr_o = {w_curAddr[31:2], 2'b00} + (w_secondPart ? 32'd4 : 32'd0);

    // Store data is rotated so byte 0 lands in lane 'off'; the same word is
    // presented for both halves of a split store.
    always_comb begin
        case (w_off)
            2'd1:    data_wdata_o = {w_curWdata[23:0], w_curWdata[31:24]};
            2'd2:    data_wdata_o = {w_curWdata[15:0], w_curWdata[31:16]};
            2'd3:    data_wdata_o = {w_curWdata[7:0],  w_curWdata[31:8]};
            default: data_wdata_o = w_curWdata;
        endcase
    end

    // State register plus request capture and first-part response latch.
    // Clearing err1 on capture keeps an aligned access from seeing a stale
    // first-part error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_addr    <= 32'd0;
            r_type    <= 2'd0;
            r_we      <= 1'b0;
            r_signExt <= 1'b0;
            r_wdata   <= 32'd0;
            r_rdata1  <= 32'd0;
            r_err1    <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            if (w_inIdle && lsu_req_i) begin
                r_addr    <= adder_result_ex_i;
                r_type    <= lsu_type_i;
                r_we      <= lsu_we_i;
                r_signExt <= lsu_sign_ext_i;
                r_wdata   <= lsu_wdata_i;
                r_err1    <= 1'b0;
            end
            if ((r_state == WAIT_RVALID_MIS) && data_rvalid_i) begin
                r_rdata1 <= data_rdata_i;
                r_err1   <= data_err_i;
            end
        end
    end

    // Next-state, bus request and response strobes. A first-part error is
    // only remembered; the second part is still issued.
    always_comb begin
        w_stateNext = r_state;
        w_busReq    = 1'b0;
        w_respValid = 1'b0;
        w_respErr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (lsu_req_i) begin
                    if (w_misaligned && !MisalignedSplit) begin
                        w_stateNext = ERR_RESP;
                    end else begin
                        w_busReq = 1'b1;
                        if (w_misaligned) begin
                            w_stateNext = data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
                        end else begin
                            w_stateNext = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                        end
                    end
                end
            end
            WAIT_GNT_MIS: begin
                w_busReq = 1'b1;
                if (data_gnt_i) begin
                    w_stateNext = WAIT_RVALID_MIS;
                end
            end
            WAIT_RVALID_MIS: begin
                if (data_rvalid_i) begin
                    w_stateNext = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                w_busReq = 1'b1;
                if (data_gnt_i) begin
                    w_stateNext = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    w_respValid = 1'b1;
                    w_respErr   = r_err1 | data_err_i;
                    w_stateNext = IDLE;
                end
            end
            ERR_RESP: begin
                w_respValid = 1'b1;
                w_respErr   = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign data_req_o = w_busReq & ~rst_i;
    assign data_we_o  = data_req_o & w_curWe;
    assign lsu_busy_o = ~w_inIdle;

    // Load alignment: {part2, part1} shifted right by the byte offset. For
    // an aligned access both parts are the current bus data.
    assign w_part1 = w_splitAccess ? r_rdata1 : data_rdata_i;

    always_comb begin
        case (w_off)
            2'd1:    w_raw = {data_rdata_i[7:0],  w_part1[31:8]};
            2'd2:    w_raw = {data_rdata_i[15:0], w_part1[31:16]};
            2'd3:    w_raw = {data_rdata_i[23:0], w_part1[31:24]};
            default: w_raw = w_part1;
        endcase
    end

    always_comb begin
        if (w_isByte) begin
            w_loadExt = {{24{r_signExt & w_raw[7]}}, w_raw[7:0]};
        end else if (w_isHalf) begin
            w_loadExt = {{16{r_signExt & w_raw[15]}}, w_raw[15:0]};
        end else begin
            w_loadExt = w_raw;
        end
    end

    assign lsu_resp_valid_o = w_respValid;
    assign lsu_resp_err_o   = w_respErr;
    assign rf_we_lsu_o      = w_respValid & ~r_we & ~w_respErr;
    assign rf_wdata_lsu_o   = rf_we_lsu_o ? w_loadExt : 32'd0;

endmodule

// File: tb/tb_cve2_lsu_split.sv
// ---------------------------------------------------------------------------
// tb_cve2_lsu_split
// Directed bench for cve2_lsu_split. Expected bus transactions and responses
// are queued when a request is driven and compared by a negedge monitor when
// the DUT grants/responds. A second instance with MisalignedSplit = 0 shares
// the stimulus and is checked for its immediate error response.
// ---------------------------------------------------------------------------
module tb_cve2_lsu_split;

    logic        clk;
    logic        rst;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sign_ext_i;
    logic [31:0] adder_result_ex_i;
    logic [31:0] lsu_wdata_i;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_rdata_i;

    logic        lsu_busy_o;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] rf_wdata_lsu_o;
    logic        rf_we_lsu_o;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;

    logic        d0_lsu_busy_o;
    logic        d0_data_req_o;
    logic [31:0] d0_data_addr_o;
    logic        d0_data_we_o;
    logic [3:0]  d0_data_be_o;
    logic [31:0] d0_data_wdata_o;
    logic [31:0] d0_rf_wdata_lsu_o;
    logic        d0_rf_we_lsu_o;
    logic        d0_lsu_resp_valid_o;
    logic        d0_lsu_resp_err_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } busExp_t;

    typedef struct packed {
        logic        err;
        logic        rfWe;
        logic [31:0] rfWdata;
    } respExp_t;

    busExp_t  busQ[$];
    respExp_t respQ[$];
    busExp_t  monBus;
    respExp_t monResp;

    int          total;
    int          bad;
    logic [31:0] rnd;

    cve2_lsu_split #(.MisalignedSplit(1'b1)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .lsu_req_i         (lsu_req_i),
        .lsu_we_i          (lsu_we_i),
        .lsu_type_i        (lsu_type_i),
        .lsu_sign_ext_i    (lsu_sign_ext_i),
        .adder_result_ex_i (adder_result_ex_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .lsu_busy_o        (lsu_busy_o),
        .data_req_o        (data_req_o),
        .data_gnt_i        (data_gnt_i),
        .data_addr_o       (data_addr_o),
        .data_we_o         (data_we_o),
        .data_be_o         (data_be_o),
        .data_wdata_o      (data_wdata_o),
        .data_rvalid_i     (data_rvalid_i),
        .data_err_i        (data_err_i),
        .data_rdata_i      (data_rdata_i),
        .rf_wdata_lsu_o    (rf_wdata_lsu_o),
        .rf_we_lsu_o       (rf_we_lsu_o),
        .lsu_resp_valid_o  (lsu_resp_valid_o),
        .lsu_resp_err_o    (lsu_resp_err_o)
    );

    cve2_lsu_split #(.MisalignedSplit(1'b0)) dutNoSplit (
        .clk_i             (clk),
        .rst_i             (rst),
        .lsu_req_i         (lsu_req_i),
        .lsu_we_i          (lsu_we_i),
        .lsu_type_i        (lsu_type_i),
        .lsu_sign_ext_i    (lsu_sign_ext_i),
        .adder_result_ex_i (adder_result_ex_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .lsu_busy_o        (d0_lsu_busy_o),
        .data_req_o        (d0_data_req_o),
        .data_gnt_i        (data_gnt_i),
        .data_addr_o       (d0_data_addr_o),
        .data_we_o         (d0_data_we_o),
        .data_be_o         (d0_data_be_o),
        .data_wdata_o      (d0_data_wdata_o),
        .data_rvalid_i     (data_rvalid_i),
        .data_err_i        (data_err_i),
        .data_rdata_i      (data_rdata_i),
        .rf_wdata_lsu_o    (d0_rf_wdata_lsu_o),
        .rf_we_lsu_o       (d0_rf_we_lsu_o),
        .lsu_resp_valid_o  (d0_lsu_resp_valid_o),
        .lsu_resp_err_o    (d0_lsu_resp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [1:0] typ,
                                 input logic sext, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        lsu_req_i         = req;
        lsu_we_i          = we;
        lsu_type_i        = typ;
        lsu_sign_ext_i    = sext;
        adder_result_ex_i = addr;
        lsu_wdata_i       = wdata;
    endtask

    // Drops the request and scrambles the request fields, so anything the
    // unit still drives must come from its own capture registers.
    task automatic idleInputs();
        rnd = $urandom;
        applyStimulus(1'b0, rnd[0], rnd[2:1], rnd[3], $urandom, $urandom);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushBus(input logic [31:0] addr, input logic [3:0] be,
                           input logic we, input logic [31:0] wdata);
        busExp_t e;
        e.addr  = addr;
        e.be    = be;
        e.we    = we;
        e.wdata = wdata;
        busQ.push_back(e);
    endtask

    task automatic pushResp(input logic err, input logic rfWe, input logic [31:0] rfWdata);
        respExp_t e;
        e.err     = err;
        e.rfWe    = rfWe;
        e.rfWdata = rfWdata;
        respQ.push_back(e);
    endtask

    // Aligned access: gnt in cycle 0, rvalid in cycle 1, response in cycle 1.
    task automatic runAligned(input logic we, input logic [1:0] typ, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err,
                              input logic [3:0] be, input logic [31:0] busWdata,
                              input logic rfWe, input logic [31:0] rfWdata);
        pushBus({addr[31:2], 2'b00}, be, we, busWdata);
        pushResp(err, rfWe, rfWdata);
        nextCycle();
        applyStimulus(1'b1, we, typ, sext, addr, wdata);
        data_gnt_i = 1'b1;
        @(negedge clk);
        checkOutput("alignedReqC0", data_req_o, 1);
        checkOutput("alignedRespC0", lsu_resp_valid_o, 0);
        nextCycle();
        idleInputs();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_err_i    = err;
        data_rdata_i  = rdata;
        @(negedge clk);
        checkOutput("alignedRespC1", lsu_resp_valid_o, 1);
        checkOutput("alignedBusyC1", lsu_busy_o, 1);
        nextCycle();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        @(negedge clk);
        checkOutput("alignedBusyC2", lsu_busy_o, 0);
    endtask

    // Split access: req1+gnt (0), rvalid1 (1), req2+gnt (2), rvalid2 (3).
    // The no-split instance must answer with an error in cycle 1 instead.
    task automatic runSplit(input logic we, input logic [1:0] typ, input logic sext,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata1, input logic err1,
                            input logic [31:0] rdata2,
                            input logic [31:0] addr1, input logic [31:0] addr2,
                            input logic [3:0] be1, input logic [3:0] be2,
                            input logic [31:0] busWdata, input logic expErr,
                            input logic rfWe, input logic [31:0] rfWdata);
        pushBus(addr1, be1, we, busWdata);
        pushBus(addr2, be2, we, busWdata);
        pushResp(expErr, rfWe, rfWdata);
        nextCycle();
        applyStimulus(1'b1, we, typ, sext, addr, wdata);
        data_gnt_i = 1'b1;
        @(negedge clk);
        checkOutput("splitReqC0", data_req_o, 1);
        checkOutput("noSplitReqC0", d0_data_req_o, 0);
        nextCycle();
        idleInputs();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_err_i    = err1;
        data_rdata_i  = rdata1;
        @(negedge clk);
        checkOutput("splitReqC1", data_req_o, 0);
        checkOutput("splitRespC1", lsu_resp_valid_o, 0);
        checkOutput("noSplitRespC1", d0_lsu_resp_valid_o, 1);
        checkOutput("noSplitErrC1", d0_lsu_resp_err_o, 1);
        checkOutput("noSplitRfWeC1", d0_rf_we_lsu_o, 0);
        nextCycle();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_gnt_i    = 1'b1;
        data_rdata_i  = $urandom;
        @(negedge clk);
        checkOutput("splitReqC2", data_req_o, 1);
        checkOutput("noSplitBusyC2", d0_lsu_busy_o, 0);
        nextCycle();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = rdata2;
        @(negedge clk);
        checkOutput("splitRespC3", lsu_resp_valid_o, 1);
        nextCycle();
        data_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput("splitBusyC4", lsu_busy_o, 0);
    endtask

    // Scoreboard monitor: every granted bus request and every response must
    // match the next queued expectation.
    always @(negedge clk) begin
        if (data_req_o && data_gnt_i) begin
            if (busQ.size() == 0) begin
                checkOutput("busUnexpectedReq", data_req_o, 0);
            end else begin
                monBus = busQ.pop_front();
                checkOutput("busAddr", data_addr_o, monBus.addr);
                checkOutput("busBe", {28'd0, data_be_o}, {28'd0, monBus.be});
                checkOutput("busWe", data_we_o, monBus.we);
                if (monBus.we) begin
                    checkOutput("busWdata", data_wdata_o, monBus.wdata);
                end
            end
        end
        if (lsu_resp_valid_o) begin
            if (respQ.size() == 0) begin
                checkOutput("respUnexpected", lsu_resp_valid_o, 0);
            end else begin
                monResp = respQ.pop_front();
                checkOutput("respErr", lsu_resp_err_o, monResp.err);
                checkOutput("respRfWe", rf_we_lsu_o, monResp.rfWe);
                checkOutput("respRfWdata", rf_wdata_lsu_o, monResp.rfWdata);
            end
        end
    end

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = 32'd0;
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_1000, 32'h1234_5678);

        // Reset: request held high but the bus must stay quiet.
        @(negedge clk);
        checkOutput("rstDataReq", data_req_o, 0);
        checkOutput("rstDataWe", data_we_o, 0);
        checkOutput("rstBusy", lsu_busy_o, 0);
        checkOutput("rstRespValid", lsu_resp_valid_o, 0);
        checkOutput("rstRespErr", lsu_resp_err_o, 0);
        checkOutput("rstRfWe", rf_we_lsu_o, 0);
        checkOutput("rstRfWdata", rf_wdata_lsu_o, 0);
        nextCycle();
        rst = 1'b0;
        idleInputs();
        @(negedge clk);
        checkOutput("postRstBusy", lsu_busy_o, 0);

        // Aligned loads and stores.
        runAligned(1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 1'b0,
                   4'b1111, 32'd0, 1'b1, 32'hDEAD_BEEF);
        runAligned(1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'd0, 32'h8000_0000, 1'b0,
                   4'b1000, 32'd0, 1'b1, 32'hFFFF_FF80);
        runAligned(1'b0, 2'b10, 1'b0, 32'h0000_1003, 32'd0, 32'h8000_0000, 1'b0,
                   4'b1000, 32'd0, 1'b1, 32'h0000_0080);
        runAligned(1'b0, 2'b10, 1'b1, 32'h0000_7001, 32'd0, 32'h1234_F678, 1'b0,
                   4'b0010, 32'd0, 1'b1, 32'hFFFF_FFF6);
        runAligned(1'b1, 2'b01, 1'b0, 32'h0000_5002, 32'h0000_ABCD, 32'h5555_5555, 1'b0,
                   4'b1100, 32'hABCD_0000, 1'b0, 32'd0);
        runAligned(1'b0, 2'b01, 1'b1, 32'h0000_5002, 32'd0, 32'h8001_1234, 1'b0,
                   4'b1100, 32'd0, 1'b1, 32'hFFFF_8001);
        runAligned(1'b0, 2'b11, 1'b1, 32'h0000_6000, 32'd0, 32'h8102_0304, 1'b0,
                   4'b1111, 32'd0, 1'b1, 32'h8102_0304);
        runAligned(1'b0, 2'b00, 1'b0, 32'h0000_8000, 32'd0, 32'h0BAD_0BAD, 1'b1,
                   4'b1111, 32'd0, 1'b0, 32'd0);

        // Split accesses.
        runSplit(1'b0, 2'b00, 1'b0, 32'h0000_2002, 32'd0, 32'hAABB_CCDD, 1'b0, 32'h1122_3344,
                 32'h0000_2000, 32'h0000_2004, 4'b1100, 4'b0011, 32'd0,
                 1'b0, 1'b1, 32'h3344_AABB);
        runSplit(1'b0, 2'b00, 1'b0, 32'h0000_9001, 32'd0, 32'h4433_2211, 1'b0, 32'h8877_6655,
                 32'h0000_9000, 32'h0000_9004, 4'b1110, 4'b0001, 32'd0,
                 1'b0, 1'b1, 32'h5544_3322);
        runSplit(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hCAFE_F00D, 1'b0,
                 32'hCAFE_F00D, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1000, 4'b0111,
                 32'h7812_3456, 1'b0, 1'b0, 32'd0);
        runSplit(1'b0, 2'b01, 1'b0, 32'h0000_3003, 32'd0, 32'h7777_7777, 1'b1, 32'h6666_6666,
                 32'h0000_3000, 32'h0000_3004, 4'b1000, 4'b0001, 32'd0,
                 1'b1, 1'b0, 32'd0);
        runSplit(1'b0, 2'b01, 1'b1, 32'h0000_3003, 32'd0, 32'h80AA_BBCC, 1'b0, 32'h0000_0012,
                 32'h0000_3000, 32'h0000_3004, 4'b1000, 4'b0001, 32'd0,
                 1'b0, 1'b1, 32'h0000_1280);

        // Delayed grant, then reset while the read is outstanding.
        pushBus(32'h0000_4000, 4'b1111, 1'b0, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'd0);
        data_gnt_i = 1'b0;
        @(negedge clk);
        checkOutput("gntWaitReqC0", data_req_o, 1);
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            idleInputs();
            data_gnt_i = (i == 3);
            @(negedge clk);
            checkOutput("gntWaitReq", data_req_o, 1);
            checkOutput("gntWaitAddr", data_addr_o, 32'h0000_4000);
        end
        nextCycle();
        data_gnt_i = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        checkOutput("midRstReq", data_req_o, 0);
        checkOutput("midRstBusy", lsu_busy_o, 0);
        checkOutput("midRstResp", lsu_resp_valid_o, 0);
        nextCycle();
        rst           = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1111_1111;
        @(negedge clk);
        checkOutput("staleRvalidResp", lsu_resp_valid_o, 0);
        checkOutput("staleRvalidRfWe", rf_we_lsu_o, 0);
        checkOutput("staleRvalidBusy", lsu_busy_o, 0);
        nextCycle();
        data_rvalid_i = 1'b0;

        // The unit must work normally after the abandoned access.
        runAligned(1'b0, 2'b00, 1'b0, 32'h0000_A004, 32'd0, 32'h0102_0304, 1'b0,
                   4'b1111, 32'd0, 1'b1, 32'h0102_0304);

        nextCycle();
        checkOutput("busQueueDrained", busQ.size(), 0);
        checkOutput("respQueueDrained", respQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
